// File: rtl/multi_debouncer_pkg.sv
// Shared constants and per-channel event bundle for the multi-channel debouncer.
package btn_pkg;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 65536;
   localparam int unsigned DEF_REPEAT_DELAY    = 1000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 250000;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
      logic rpt;
   } btn_evt_t;

   // Repeat counter only needs to reach max(delay, period) - 1.
   function automatic int unsigned rpt_cnt_width(input int unsigned delay,
                                                 input int unsigned period);
      int unsigned m;
      m = (delay > period) ? delay : period;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/multi_debouncer_chan.sv
// One debounce channel: 2-flop synchroniser, symmetric filter counter, event pulses.
// Auto-repeat logic exists only when BTN_REPEAT_EN is defined.
module debounce_chan
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_raw,
   output btn_evt_t o_evt
);

   localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("debounce_chan: DEBOUNCE_CYCLES must be >= 2, repeat timings >= 1");
   end

   logic             r_s1;
   logic             r_s2;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;
   logic             w_diff;
   logic             w_term;
   logic             w_rpt;

   assign w_diff = r_s2 ^ r_level;
   assign w_term = w_diff && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1   <= i_raw;
         r_s2   <= r_s1;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_term) begin
            r_level <= r_s2;
            r_cnt   <= '0;
            r_rise  <= r_s2;
            r_fall  <= ~r_s2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef BTN_REPEAT_EN
   localparam int unsigned      RPT_W     = rpt_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] r_rcnt;
   logic             r_first;
   logic             r_rpt;
   logic             w_rpt_hit;

   assign w_rpt_hit = (r_rcnt == (r_first ? RPT_FIRST : RPT_NEXT));

   // Any acceptance (rise or fall) or a low level re-arms the initial delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rcnt  <= '0;
         r_first <= 1'b1;
         r_rpt   <= 1'b0;
      end else begin
         r_rpt <= 1'b0;
         if (w_term || !r_level) begin
            r_rcnt  <= '0;
            r_first <= 1'b1;
         end else if (w_rpt_hit) begin
            r_rpt   <= 1'b1;
            r_rcnt  <= '0;
            r_first <= 1'b0;
         end else begin
            r_rcnt <= r_rcnt + 1'b1;
         end
      end
   end

   assign w_rpt = r_rpt;
`else
   assign w_rpt = 1'b0;
`endif

   assign o_evt = '{level: r_level, rise: r_rise, fall: r_fall, rpt: w_rpt};

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer top: fans raw inputs out to debounce_chan instances.
// Optional auto-repeat is enabled with macro BTN_REPEAT_EN.
module multi_debouncer
   import btn_pkg::*;
#(
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] btn_raw,
   output logic [NUM_CH-1:0] btn_level,
   output logic [NUM_CH-1:0] btn_rise,
   output logic [NUM_CH-1:0] btn_fall,
   output logic [NUM_CH-1:0] btn_repeat
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      btn_evt_t w_evt;

      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .i_raw (btn_raw[g]),
         .o_evt (w_evt)
      );

      assign btn_level[g]  = w_evt.level;
      assign btn_rise[g]   = w_evt.rise;
      assign btn_fall[g]   = w_evt.fall;
      assign btn_repeat[g] = w_evt.rpt;
   end

endmodule
